pulse_burst_gen: RTL and testbench
==================================

Name: pulse_burst_gen

Overview:
- Parametrised successor to the fixed-count pulse generator: emits a burst of N pulses, each HIGH for H clocks and separated by L clocks.
- N, H and L are runtime inputs, latched when the burst starts.
- Adds a one-shot/repeat mode, an inter-burst gap, abort, and status outputs.
- Sits between the test-sequencer registers and the ASIC stimulus pins.

Parameters:
- CNT_W, 8, width of pulse count and pulse index
- DUR_W, 16, width of high/low/gap duration counters

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level enable; low aborts any activity
- start  in  1  burst request, sampled only in IDLE
- cfg_n_pulses  in  CNT_W  pulses per burst (N)
- cfg_high  in  DUR_W  HIGH duration in clocks (H)
- cfg_low  in  DUR_W  inter-pulse LOW duration in clocks (L)
- cfg_gap  in  DUR_W  inter-burst gap in clocks (G), repeat mode only
- cfg_repeat  in  1  0 = one-shot, 1 = continuous bursts
- pulse  out  1  generated pulse train
- busy  out  1  high while in HIGH, LOW or GAP
- done  out  1  one-clock strobe at end of each burst
- pulse_idx  out  CNT_W  index of current/last pulse, 0..N-1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; pulse=0, busy=0, done=0, pulse_idx=0.
  - Internal counters and latched config cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, HIGH, LOW, GAP.
- pulse = (state==HIGH); busy = (state != IDLE).
- Start: in IDLE, edge with en=1 and start=1:
  - Latch N, H', L', G', repeat, where H'=max(H,1), L'=max(L,1), G'=max(G,1).
  - If N>0: state becomes HIGH, pulse_idx=0, duration counter loaded.
  - If N=0: stay IDLE; done=1 for the following cycle; pulse never rises.
- HIGH: lasts exactly H' cycles.
  - If pulse_idx < N-1: go to LOW.
  - Else, one-shot: go to IDLE, done=1 for one cycle.
  - Else, repeat: go to GAP, done=1 for the first GAP cycle.
- LOW: lasts exactly L' cycles, then HIGH with pulse_idx+1.
- GAP: lasts exactly G' cycles, then HIGH with pulse_idx=0; latched config is reused.
- One-shot burst duration: N·H' + (N-1)·L' cycles of busy=1. done occurs on the cycle immediately after the last HIGH cycle.
- start while busy: ignored. cfg_* changes while busy: ignored until the next IDLE start.
- en=0 on any edge: next state IDLE, pulse=0, busy=0, done=0, pulse_idx held.
  - en has priority over start and over a coincident burst end; no done strobe on abort.
- start held high continuously in one-shot mode re-triggers on the cycle after done; the IDLE dwell is exactly 1 cycle.
- Counter widths are saturating-safe:
  - N=2^CNT_W-1 and H=2^DUR_W-1 must run to completion with no wrap.
  - pulse_idx never exceeds N-1.

Test Plan:
- Reset mid-burst: N=10, H=2, L=2, start, then drop rst_n after 5 cycles -> all outputs 0 immediately (before the next edge); no pulse after release until a new start.
- Baseline burst: N=10, H=2, L=2, one-shot -> 10 pulses of 2 clocks, each gap 2 clocks; busy high for 38 cycles; pulse_idx steps 0..9; a single done on cycle 38 after start.
- Zero/minimum config: N=0 -> pulse stays 0, done one cycle after start. N=3, H=0, L=0 -> behaves as H=1, L=1, giving pattern 10101 then done.
- Repeat mode: N=2, H=1, L=3, G=4 -> pattern 1000100001000... Check done on each first GAP cycle and pulse_idx returning to 0. Drop en mid-LOW -> IDLE next edge, no done.
- Abort vs done collision: en falls on the same edge the last HIGH ends -> no done, busy=0. start during a burst -> ignored, pulse count unchanged.
- Saturation: CNT_W=4, N=15, H=1, L=1 -> exactly 15 pulses, pulse_idx ends at 14, no wrap.

Source files
------------

// File: rtl/pulse_burst_gen.sv
// Burst pulse generator: N pulses of H clocks HIGH separated by L clocks LOW,
// optionally repeated after a G-clock gap. Config is latched at burst start.
//
// state | meaning
// IDLE  | waiting for start with en=1
// HIGH  | pulse asserted, dur_cnt counting down the H' period
// LOW   | inter-pulse low, dur_cnt counting down the L' period
// GAP   | inter-burst gap (repeat mode), dur_cnt counting down the G' period
module pulse_burst_gen #(
  parameter int CNT_W = 8,
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_n_pulses,
  input  logic [DUR_W-1:0] cfg_high,
  input  logic [DUR_W-1:0] cfg_low,
  input  logic [DUR_W-1:0] cfg_gap,
  input  logic             cfg_repeat,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [DUR_W-1:0] dur_cnt, dur_cnt_nxt;
  logic [DUR_W-1:0] high_rld, low_rld, gap_rld;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] idx_nxt;
  logic             rep_lat;
  logic             load_cfg;
  logic             done_nxt;
  logic             cnt_tc;
  logic             last_pulse;

  // Reload value is duration-1 so a zero duration behaves as one clock.
  function automatic logic [DUR_W-1:0] reload_of(input logic [DUR_W-1:0] d);
    return (d == '0) ? '0 : d - DUR_W'(1);
  endfunction

  assign cnt_tc     = (dur_cnt == '0);
  assign last_pulse = (pulse_idx == n_lat - CNT_W'(1));

  always_comb begin
    state_nxt   = state;
    dur_cnt_nxt = dur_cnt;
    idx_nxt     = pulse_idx;
    done_nxt    = 1'b0;
    load_cfg    = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            load_cfg = 1'b1;
            if (cfg_n_pulses != '0) begin
              state_nxt   = ST_HIGH;
              idx_nxt     = '0;
              dur_cnt_nxt = reload_of(cfg_high);
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (!cnt_tc) begin
            dur_cnt_nxt = dur_cnt - DUR_W'(1);
          end else if (!last_pulse) begin
            state_nxt   = ST_LOW;
            dur_cnt_nxt = low_rld;
          end else if (rep_lat) begin
            state_nxt   = ST_GAP;
            dur_cnt_nxt = gap_rld;
            done_nxt    = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
        ST_LOW: begin
          if (!cnt_tc) begin
            dur_cnt_nxt = dur_cnt - DUR_W'(1);
          end else begin
            state_nxt   = ST_HIGH;
            idx_nxt     = pulse_idx + CNT_W'(1);
            dur_cnt_nxt = high_rld;
          end
        end
        ST_GAP: begin
          if (!cnt_tc) begin
            dur_cnt_nxt = dur_cnt - DUR_W'(1);
          end else begin
            state_nxt   = ST_HIGH;
            idx_nxt     = '0;
            dur_cnt_nxt = high_rld;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dur_cnt   <= '0;
      pulse_idx <= '0;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      n_lat     <= '0;
      high_rld  <= '0;
      low_rld   <= '0;
      gap_rld   <= '0;
      rep_lat   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dur_cnt   <= dur_cnt_nxt;
      pulse_idx <= idx_nxt;
      // Outputs come from flops fed by next-state decode, so they are glitch-free.
      pulse     <= (state_nxt == ST_HIGH);
      busy      <= (state_nxt != ST_IDLE);
      done      <= done_nxt;
      if (load_cfg) begin
        n_lat    <= cfg_n_pulses;
        high_rld <= reload_of(cfg_high);
        low_rld  <= reload_of(cfg_low);
        gap_rld  <= reload_of(cfg_gap);
        rep_lat  <= cfg_repeat;
      end
    end
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen: a CNT_W=8 instance plus a CNT_W=4
// instance sharing the stimulus, for the pulse-count saturation corner.
module tb_pulse_burst_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic        cfg_repeat = 1'b0;
  logic [7:0]  cfg_n_pulses = '0;
  logic [15:0] cfg_high = '0;
  logic [15:0] cfg_low = '0;
  logic [15:0] cfg_gap = '0;
  logic        pulse, busy, done;
  logic [7:0]  pulse_idx;
  logic        pulse4, busy4, done4;
  logic [3:0]  pulse_idx4;

  always #5 clk = ~clk;

  pulse_burst_gen #(.CNT_W(8), .DUR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start),
    .cfg_n_pulses(cfg_n_pulses), .cfg_high(cfg_high), .cfg_low(cfg_low),
    .cfg_gap(cfg_gap), .cfg_repeat(cfg_repeat),
    .pulse(pulse), .busy(busy), .done(done), .pulse_idx(pulse_idx)
  );

  pulse_burst_gen #(.CNT_W(4), .DUR_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start),
    .cfg_n_pulses(cfg_n_pulses[3:0]), .cfg_high(cfg_high), .cfg_low(cfg_low),
    .cfg_gap(cfg_gap), .cfg_repeat(cfg_repeat),
    .pulse(pulse4), .busy(busy4), .done(done4), .pulse_idx(pulse_idx4)
  );

  int n_vec = 0;
  int n_err = 0;

  int cp[600], cb[600], cd[600], cix[600];
  int cp4[600], cd4[600], cix4[600];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample k consecutive cycles (position 0 = state right after the start edge).
  task automatic capture(input int k);
    for (int c = 0; c < k; c++) begin
      cp[c]   = int'(pulse);
      cb[c]   = int'(busy);
      cd[c]   = int'(done);
      cix[c]  = int'(pulse_idx);
      cp4[c]  = int'(pulse4);
      cd4[c]  = int'(done4);
      cix4[c] = int'(pulse_idx4);
      step();
    end
  endtask

  task automatic start_burst(input int n, input int h, input int l, input int g,
                             input int rep);
    cfg_n_pulses = 8'(n);
    cfg_high     = 16'(h);
    cfg_low      = 16'(l);
    cfg_gap      = 16'(g);
    cfg_repeat   = rep[0];
    en           = 1'b1;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  function automatic int sum_of(input int k, input int sel);
    int s = 0;
    for (int c = 0; c < k; c++)
      s += (sel == 0) ? cp[c] : (sel == 1) ? cb[c] : (sel == 2) ? cd[c] : cp4[c];
    return s;
  endfunction

  function automatic int first_done(input int k, input int sel);
    for (int c = 0; c < k; c++)
      if (((sel == 0) ? cd[c] : cd4[c]) != 0) return c;
    return -1;
  endfunction

  initial begin
    int errs_p, errs_b, errs_d, errs_i, pat, pat_d, pat_b;

    #1;
    chk("reset_pulse", int'(pulse), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_idx", int'(pulse_idx), 0);
    #11 rst_n = 1'b1;
    step();

    // Reset mid-burst: position 5 is the second pulse HIGH, idx 1
    start_burst(10, 2, 2, 0, 0);
    capture(5);
    chk("pre_reset_pulse", int'(pulse), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pulse", int'(pulse), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_idx", int'(pulse_idx), 0);
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    capture(10);
    chk("postrst_pulses", sum_of(10, 0), 0);
    chk("postrst_busy", sum_of(10, 1), 0);

    // Baseline: 10 pulses of 2, lows of 2, busy 38, done at position 38
    start_burst(10, 2, 2, 0, 0);
    capture(45);
    errs_p = 0; errs_b = 0; errs_d = 0; errs_i = 0;
    for (int c = 0; c < 45; c++) begin
      if (cp[c] != ((c < 38 && (c % 4) < 2) ? 1 : 0)) errs_p++;
      if (cb[c] != ((c < 38) ? 1 : 0)) errs_b++;
      if (cd[c] != ((c == 38) ? 1 : 0)) errs_d++;
      if (cix[c] != ((c < 38) ? c / 4 : 9)) errs_i++;
    end
    chk("base_pulse_errs", errs_p, 0);
    chk("base_busy_errs", errs_b, 0);
    chk("base_done_errs", errs_d, 0);
    chk("base_idx_errs", errs_i, 0);
    chk("base_busy_cycles", sum_of(45, 1), 38);
    chk("base_done_pos", first_done(45, 0), 38);

    // N=0: done the cycle after start, no pulse
    start_burst(0, 5, 5, 0, 0);
    capture(4);
    chk("n0_done_pos", first_done(4, 0), 0);
    chk("n0_done_count", sum_of(4, 2), 1);
    chk("n0_pulses", sum_of(4, 0), 0);
    chk("n0_busy", sum_of(4, 1), 0);

    // N=3, H=0, L=0 -> 10101 then done
    start_burst(3, 0, 0, 0, 0);
    capture(8);
    pat = 0;
    for (int c = 0; c < 6; c++) pat = (pat << 1) | cp[c];
    chk("min_pattern", pat, 'b101010);
    chk("min_done_pos", first_done(8, 0), 5);
    chk("min_busy", sum_of(8, 1), 5);

    // Repeat: N=2,H=1,L=3,G=4, period 9
    start_burst(2, 1, 3, 4, 1);
    capture(20);
    errs_p = 0; errs_d = 0; errs_i = 0; errs_b = 0;
    for (int c = 0; c < 20; c++) begin
      if (cp[c] != (((c % 9) == 0 || (c % 9) == 4) ? 1 : 0)) errs_p++;
      if (cd[c] != (((c % 9) == 5) ? 1 : 0)) errs_d++;
      if (cix[c] != (((c % 9) < 4) ? 0 : 1)) errs_i++;
      if (cb[c] != 1) errs_b++;
    end
    chk("rep_pulse_errs", errs_p, 0);
    chk("rep_done_errs", errs_d, 0);
    chk("rep_idx_errs", errs_i, 0);
    chk("rep_busy_errs", errs_b, 0);
    chk("rep_done_count", sum_of(20, 2), 2);
    en = 1'b0;
    step();
    chk("abort_low_busy", int'(busy), 0);
    chk("abort_low_pulse", int'(pulse), 0);
    chk("abort_low_done", int'(done), 0);
    capture(5);
    chk("abort_low_quiet", sum_of(5, 1) + sum_of(5, 2), 0);
    en = 1'b1;
    cfg_repeat = 1'b0;

    // en drops on the edge that ends the last HIGH
    start_burst(2, 1, 1, 0, 0);
    capture(2);
    en = 1'b0;
    step();
    chk("coll_done", int'(done), 0);
    chk("coll_busy", int'(busy), 0);
    chk("coll_idx_held", int'(pulse_idx), 1);
    step();
    chk("coll_done_late", int'(done), 0);
    en = 1'b1;

    // start and cfg changes during a burst are ignored
    start_burst(4, 1, 1, 0, 0);
    for (int c = 0; c < 12; c++) begin
      start = (c >= 1 && c <= 4);
      if (c == 1) begin
        cfg_n_pulses = 8'd9;
        cfg_high     = 16'd3;
      end
      cp[c] = int'(pulse);
      cb[c] = int'(busy);
      cd[c] = int'(done);
      step();
    end
    start = 1'b0;
    chk("busy_start_pulses", sum_of(12, 0), 4);
    chk("busy_start_busy", sum_of(12, 1), 7);
    chk("busy_start_done", first_done(12, 0), 7);

    // start held high in one-shot: one IDLE cycle then retrigger
    cfg_n_pulses = 8'd2; cfg_high = 16'd1; cfg_low = 16'd1; cfg_repeat = 1'b0;
    start = 1'b1;
    step();
    pat = 0; pat_d = 0; pat_b = 0;
    for (int c = 0; c < 6; c++) begin
      pat   = (pat << 1) | int'(pulse);
      pat_d = (pat_d << 1) | int'(done);
      pat_b = (pat_b << 1) | int'(busy);
      step();
    end
    start = 1'b0;
    chk("retrig_pulse", pat, 'b101010);
    chk("retrig_done", pat_d, 'b000100);
    chk("retrig_busy", pat_b, 'b111011);
    capture(6);

    // Saturation on the 4-bit instance: N=15 -> 15 pulses, idx ends at 14
    start_burst(15, 1, 1, 0, 0);
    capture(32);
    chk("sat4_pulses", sum_of(32, 3), 15);
    chk("sat4_done_pos", first_done(32, 1), 29);
    chk("sat4_idx_final", cix4[31], 14);
    errs_i = 0;
    for (int c = 0; c < 32; c++) if (cix4[c] > 14) errs_i++;
    chk("sat4_idx_range", errs_i, 0);

    // Full-width N=255 on the 8-bit instance
    start_burst(255, 1, 1, 0, 0);
    capture(520);
    chk("sat8_pulses", sum_of(520, 0), 255);
    chk("sat8_busy", sum_of(520, 1), 509);
    chk("sat8_done_pos", first_done(520, 0), 509);
    chk("sat8_idx_final", cix[519], 254);

    // Long HIGH exercising upper duration counter bits
    start_burst(1, 300, 0, 0, 0);
    capture(305);
    chk("longh_busy", sum_of(305, 1), 300);
    chk("longh_done_pos", first_done(305, 0), 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
